id_ex_stage: RTL

ID/EX pipeline register and operand-forwarding stage of the five-stage pipelined MIPS core. It captures decoded instructions from the ID stage and presents resolved operands to the ALU: `ex_op1`, `ex_op2`, `ex_opcode`, `ex_ar_op` and `ex_shamt`. It also forwards results from the EX/MEM and MEM/WB registers, detects load-use hazards and inserts bubbles on stall or flush. A saturating bubble counter is provided for performance debug.

---
 rtl/id_ex_stage.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding,
// load-use stall detection and a saturating bubble counter.
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_funct,
    input  logic [4:0]       id_shamt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_dest,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_rt_data,
    input  logic [15:0]      id_imm,
    input  logic             id_use_imm,
    input  logic             id_sign_ext,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_dest,
    input  logic [31:0]      mem_result,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_dest,
    input  logic [31:0]      wb_result,
    input  logic             flush,
    output logic             stall_id,
    output logic             ex_valid,
    output logic [5:0]       ex_opcode,
    output logic [5:0]       ex_ar_op,
    output logic [4:0]       ex_shamt,
    output logic [31:0]      ex_op1,
    output logic [31:0]      ex_op2,
    output logic [31:0]      ex_store_data,
    output logic [4:0]       ex_dest,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic [CNT_W-1:0] bubble_count
);

    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [5:0]  ar_op;
        logic [4:0]  shamt;
        logic [4:0]  dest;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        use_imm;
        logic        sign_ext;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [15:0] imm;
    } id_ex_t;

    id_ex_t ex_q;
    id_ex_t ex_d;
    logic   bubble;
    logic   rs_hit;
    logic   rt_hit;
    logic   [31:0] rs_fwd;
    logic   [31:0] rt_fwd;
    logic   [31:0] imm_ext;

    // Register-file read with write-through of the WB result
    function automatic logic [31:0] rf_read(
        input logic [4:0]  src,
        input logic [31:0] rf,
        input logic        w_en,
        input logic [4:0]  w_dst,
        input logic [31:0] w_res
    );
        if (src == 5'd0)
            return 32'd0;
        if (w_en && w_dst != 5'd0 && w_dst == src)
            return w_res;
        return rf;
    endfunction

    function automatic logic [31:0] fwd(
        input logic [4:0]  src,
        input logic [31:0] cap,
        input logic        m_en,
        input logic [4:0]  m_dst,
        input logic [31:0] m_res,
        input logic        w_en,
        input logic [4:0]  w_dst,
        input logic [31:0] w_res
    );
        if (m_en && m_dst != 5'd0 && m_dst == src)
            return m_res;
        if (w_en && w_dst != 5'd0 && w_dst == src)
            return w_res;
        return cap;
    endfunction

    assign rs_hit = ex_q.dest == id_rs;
    assign rt_hit = ex_q.dest == id_rt
                    && (!id_use_imm || id_mem_write);

    assign stall_id = !flush
                      && ex_q.valid
                      && ex_q.mem_read
                      && ex_q.dest != 5'd0
                      && (rs_hit || rt_hit);

    assign bubble = flush || stall_id || !id_valid;

    always_comb begin
        ex_d = '0;
        if (!bubble) begin
            ex_d.valid     = 1'b1;
            ex_d.opcode    = id_opcode;
            ex_d.ar_op     = id_funct;
            ex_d.shamt     = id_shamt;
            ex_d.dest      = id_dest;
            ex_d.rs        = id_rs;
            ex_d.rt        = id_rt;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_d.mem_write = id_mem_write;
            ex_d.use_imm   = id_use_imm;
            ex_d.sign_ext  = id_sign_ext;
            ex_d.imm       = id_imm;
            ex_d.rs_data   = rf_read(id_rs, id_rs_data,
                                     wb_reg_write, wb_dest,
                                     wb_result);
            ex_d.rt_data   = rf_read(id_rt, id_rt_data,
                                     wb_reg_write, wb_dest,
                                     wb_result);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q         <= '0;
            bubble_count <= '0;
        end else begin
            ex_q <= ex_d;
            if (bubble && id_valid
                && bubble_count != {CNT_W{1'b1}})
                bubble_count <= bubble_count + CNT_W'(1);
        end
    end

    assign rs_fwd = fwd(ex_q.rs, ex_q.rs_data,
                        mem_reg_write, mem_dest, mem_result,
                        wb_reg_write, wb_dest, wb_result);
    assign rt_fwd = fwd(ex_q.rt, ex_q.rt_data,
                        mem_reg_write, mem_dest, mem_result,
                        wb_reg_write, wb_dest, wb_result);

    assign imm_ext = ex_q.sign_ext
                     ? {{16{ex_q.imm[15]}}, ex_q.imm}
                     : {16'd0, ex_q.imm};

    assign ex_op1        = rs_fwd;
    assign ex_op2        = ex_q.use_imm ? imm_ext : rt_fwd;
    assign ex_store_data = rt_fwd;
    assign ex_valid      = ex_q.valid;
    assign ex_opcode     = ex_q.opcode;
    assign ex_ar_op      = ex_q.ar_op;
    assign ex_shamt      = ex_q.shamt;
    assign ex_dest       = ex_q.dest;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;

endmodule
